lcd_write_arbiter: RTL and testbench

//  Shares the 4-bit character-LCD bus between two requesters once power-on init is complete.

---
 rtl/lcd_write_arbiter.sv | 170 +++++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter for the 4-bit character-LCD bus.
// Splits each accepted byte into timed high/low nibble writes.
module lcd_write_arbiter #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 50,
  parameter int T_BYTE  = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iInitDone,
  input  logic       iReq0_Valid,
  input  logic       iReq0_RegisterSelect,
  input  logic [7:0] iReq0_Byte,
  output logic       oReq0_Ready,
  input  logic       iReq1_Valid,
  input  logic       iReq1_RegisterSelect,
  input  logic [7:0] iReq1_Byte,
  output logic       oReq1_Ready,
  output logic       oBusy,
  output logic       oByteDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  localparam int CW = $clog2(T_SETUP + T_PULSE + T_HOLD
                             + T_GAP + T_BYTE + T_CLEAR + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t L_SETUP = cnt_t'(T_SETUP - 1);
  localparam cnt_t L_PULSE = cnt_t'(T_PULSE - 1);
  localparam cnt_t L_HOLD  = cnt_t'(T_HOLD - 1);
  localparam cnt_t L_GAP   = cnt_t'(T_GAP - 1);
  localparam cnt_t L_BYTE  = cnt_t'(T_BYTE - 1);
  localparam cnt_t L_CLEAR = cnt_t'(T_CLEAR - 1);

  typedef enum logic [3:0] {
    IDLE, SETUP_HI, PULSE_HI, HOLD_HI, GAP,
    SETUP_LO, PULSE_LO, HOLD_LO, WAIT
  } state_t;

  state_t     state;
  cnt_t       count;
  cnt_t       limit;
  cnt_t       waitLast;
  logic [7:0] byteQ;
  logic       rsQ;
  logic       lastGrant;
  logic       isClear;
  logic       stateEnd;
  logic       canAccept;
  logic       pick0;
  logic       pick1;

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  // Clear display / return home need the long settle time
  always_comb begin
    isClear  = !rsQ && (byteQ[7:2] == 6'd0) && (byteQ != 8'd0);
    waitLast = isClear ? L_CLEAR : L_BYTE;
  end

  always_comb begin
    limit = '0;
    unique case (state)
      SETUP_HI, SETUP_LO: limit = L_SETUP;
      PULSE_HI, PULSE_LO: limit = L_PULSE;
      HOLD_HI, HOLD_LO:   limit = L_HOLD;
      GAP:                limit = L_GAP;
      WAIT:               limit = waitLast;
      default:            limit = '0;
    endcase
    stateEnd = (count == limit);
  end

  always_comb begin
    canAccept   = !Reset && iInitDone && (state == IDLE);
    pick0       = iReq0_Valid && (!iReq1_Valid || lastGrant);
    pick1       = iReq1_Valid && (!iReq0_Valid || !lastGrant);
    oReq0_Ready = canAccept && pick0;
    oReq1_Ready = canAccept && pick1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state               <= IDLE;
      count               <= '0;
      byteQ               <= 8'd0;
      rsQ                 <= 1'b0;
      lastGrant           <= 1'b1;
      oBusy               <= 1'b0;
      oByteDone           <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= 4'd0;
    end else if (state == IDLE) begin
      count <= '0;
      unique case (1'b1)
        oReq0_Ready: begin
          byteQ               <= iReq0_Byte;
          rsQ                 <= iReq0_RegisterSelect;
          oLCD_RegisterSelect <= iReq0_RegisterSelect;
          oLCD_Data           <= iReq0_Byte[7:4];
          lastGrant           <= 1'b0;
          oBusy               <= 1'b1;
          state               <= SETUP_HI;
        end
        oReq1_Ready: begin
          byteQ               <= iReq1_Byte;
          rsQ                 <= iReq1_RegisterSelect;
          oLCD_RegisterSelect <= iReq1_RegisterSelect;
          oLCD_Data           <= iReq1_Byte[7:4];
          lastGrant           <= 1'b1;
          oBusy               <= 1'b1;
          state               <= SETUP_HI;
        end
        default: ;
      endcase
    end else begin
      count <= stateEnd ? '0 : count + cnt_t'(1);
      if (state == WAIT && !stateEnd)
        oByteDone <= (count + cnt_t'(1) == waitLast);
      if (stateEnd) begin
        unique case (state)
          SETUP_HI: begin
            state        <= PULSE_HI;
            oLCD_Enabled <= 1'b1;
          end
          PULSE_HI: begin
            state        <= HOLD_HI;
            oLCD_Enabled <= 1'b0;
          end
          HOLD_HI: state <= GAP;
          GAP: begin
            state     <= SETUP_LO;
            oLCD_Data <= byteQ[3:0];
          end
          SETUP_LO: begin
            state        <= PULSE_LO;
            oLCD_Enabled <= 1'b1;
          end
          PULSE_LO: begin
            state        <= HOLD_LO;
            oLCD_Enabled <= 1'b0;
          end
          HOLD_LO: begin
            state     <= WAIT;
            oByteDone <= (waitLast == '0);
          end
          WAIT: begin
            state               <= IDLE;
            oBusy               <= 1'b0;
            oByteDone           <= 1'b0;
            oLCD_Data           <= 4'd0;
            oLCD_RegisterSelect <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: directed scenarios plus random
// traffic checked each cycle against a waveform-level model.
module tb_lcd_write_arbiter;

  localparam int S  = 2;
  localparam int P  = 12;
  localparam int H  = 1;
  localparam int G  = 7;
  localparam int WB = 30;
  localparam int WC = 90;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iInitDone = 1'b0;
  logic       v0 = 1'b0;
  logic       rs0 = 1'b0;
  logic [7:0] b0 = 8'd0;
  logic       v1 = 1'b0;
  logic       rs1 = 1'b0;
  logic [7:0] b1 = 8'd0;
  logic       oReq0_Ready;
  logic       oReq1_Ready;
  logic       oBusy;
  logic       oByteDone;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic       oLCD_ReadWrite;
  logic       oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  always #5 Clock = ~Clock;

  lcd_write_arbiter #(
    .T_SETUP(S), .T_PULSE(P), .T_HOLD(H),
    .T_GAP(G), .T_BYTE(WB), .T_CLEAR(WC)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iInitDone(iInitDone),
    .iReq0_Valid(v0),
    .iReq0_RegisterSelect(rs0),
    .iReq0_Byte(b0),
    .oReq0_Ready(oReq0_Ready),
    .iReq1_Valid(v1),
    .iReq1_RegisterSelect(rs1),
    .iReq1_Byte(b1),
    .oReq1_Ready(oReq1_Ready),
    .oBusy(oBusy),
    .oByteDone(oByteDone),
    .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oLCD_Data(oLCD_Data)
  );

  int tests = 0;
  int fails = 0;

  // Model state: which byte is on the bus and since when
  int         cyc = 0;
  bit         mBusy = 1'b0;
  int         mStart = 0;
  logic [7:0] mByte = 8'd0;
  logic       mRs = 1'b0;
  bit         mLast = 1'b1;
  bit         mAcc0 = 1'b0;
  bit         mAcc1 = 1'b0;
  int         accepts = 0;
  bit         chkOn = 1'b0;
  int         grants[$];

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int total(logic [7:0] b, logic rs);
    bit clr;
    clr = !rs && b != 8'd0 && b < 8'd4;
    return 2 * (S + P + H) + G + (clr ? WC : WB);
  endfunction

  // {done, busy, E, RS, data} at offset k into a byte
  function automatic logic [7:0] wave(int k, logic [7:0] b, logic rs);
    int lo;
    logic e;
    logic [3:0] d;
    lo = S + P + H + G;
    e = (k >= S && k < S + P) || (k >= lo + S && k < lo + S + P);
    if (k < lo) d = b[7:4];
    else d = b[3:0];
    return {k == total(b, rs) - 1, 1'b1, e, rs, d};
  endfunction

  function automatic logic [1:0] mReady();
    logic r0;
    logic r1;
    if (mBusy || !iInitDone || Reset) return 2'b00;
    r0 = v0 && (!v1 || mLast);
    r1 = v1 && (!v0 || !mLast);
    return {r1, r0};
  endfunction

  always @(posedge Clock) begin
    logic [1:0] rd;
    rd = mReady();
    mAcc0 = 1'b0;
    mAcc1 = 1'b0;
    if (Reset) begin
      mBusy = 1'b0;
      mLast = 1'b1;
    end else if (mBusy) begin
      if (cyc - mStart == total(mByte, mRs) - 1) mBusy = 1'b0;
    end else if (rd != 2'b00) begin
      mAcc0  = rd[0];
      mAcc1  = rd[1];
      mByte  = rd[0] ? b0 : b1;
      mRs    = rd[0] ? rs0 : rs1;
      mLast  = rd[1];
      mBusy  = 1'b1;
      mStart = cyc + 1;
      accepts++;
    end
    cyc++;
  end

  always @(negedge Clock) begin
    logic [11:0] act;
    logic [11:0] exp;
    logic [7:0]  w;
    if (chkOn && !Reset) begin
      act = {oReq1_Ready, oReq0_Ready, oLCD_ReadWrite,
             oLCD_StrataFlashControl, oByteDone, oBusy,
             oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data};
      if (mBusy) begin
        w = wave(cyc - mStart, mByte, mRs);
        exp = {2'b00, 1'b0, 1'b1, w};
      end else begin
        exp = {mReady(), 1'b0, 1'b1, 8'h00};
      end
      tests++;
      if (act != exp) begin
        fails++;
        $display("FAIL cycle_model @%0d: got %h expected %h",
                 cyc, act, exp);
      end
      if (oReq0_Ready && v0) grants.push_back(0);
      if (oReq1_Ready && v1) grants.push_back(1);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(int r, logic rs, logic [7:0] b);
    bit ok;
    ok = 1'b0;
    if (r == 0) begin v0 = 1'b1; rs0 = rs; b0 = b; end
    else begin v1 = 1'b1; rs1 = rs; b1 = b; end
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = (r == 0) ? mAcc0 : mAcc1;
    end
    if (r == 0) v0 = 1'b0;
    else v1 = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  // Observes one byte from the first busy cycle until idle
  task automatic measure(string name, int expBusy,
                         logic [3:0] hi, logic [3:0] lo);
    int nb;
    int ne;
    int nd;
    logic pe;
    logic [3:0] nib[2];
    int nn;
    nb = 0; ne = 0; nd = 0; pe = 1'b0; nn = 0;
    nib[0] = 4'hx; nib[1] = 4'hx;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clock);
      if (!oBusy) break;
      nb++;
      ne += int'(oLCD_Enabled);
      nd += int'(oByteDone);
      if (oLCD_Enabled && !pe && nn < 2) begin
        nib[nn] = oLCD_Data;
        nn++;
      end
      pe = oLCD_Enabled;
    end
    check({name, "_busy"}, nb, expBusy);
    check({name, "_ecycles"}, ne, 2 * P);
    check({name, "_done"}, nd, 1);
    check({name, "_hi"}, int'(nib[0]), int'(hi));
    check({name, "_lo"}, int'(nib[1]), int'(lo));
    tick();
  endtask

  function automatic logic [8:0] rndByte();
    if ($urandom_range(0, 3) == 0)
      return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 3))};
    return 9'($urandom);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    logic [8:0] rb;

    repeat (3) tick();
    Reset = 1'b0;
    chkOn = 1'b1;
    @(negedge Clock);
    check("reset_busy", int'(oBusy), 0);
    check("reset_e", int'(oLCD_Enabled), 0);
    check("reset_data", int'(oLCD_Data), 0);
    check("reset_done", int'(oByteDone), 0);
    check("reset_sf", int'(oLCD_StrataFlashControl), 1);
    tick();

    // Single data byte 0x41
    iInitDone = 1'b1;
    send(0, 1'b1, 8'h41);
    measure("t1", 67, 4'h4, 4'h1);

    // Both requesters valid from reset: strict alternation
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    grants.delete();
    v0 = 1'b1; rs0 = 1'b1; b0 = 8'h30;
    v1 = 1'b1; rs1 = 1'b1; b1 = 8'h31;
    n = 0;
    for (int i = 0; i < 2000 && n < 4; i++) begin
      tick();
      if (mAcc0 || mAcc1) n++;
    end
    v0 = 1'b0;
    v1 = 1'b0;
    measure("t2_last", 67, 4'h3, 4'h1);
    check("t2_count", grants.size(), 4);
    if (grants.size() == 4) begin
      check("t2_g0", grants[0], 0);
      check("t2_g1", grants[1], 1);
      check("t2_g2", grants[2], 0);
      check("t2_g3", grants[3], 1);
    end

    // Clear/home classification
    send(1, 1'b0, 8'h01);
    measure("t3_clear", 127, 4'h0, 4'h1);
    send(1, 1'b0, 8'h04);
    measure("t3_cmd04", 67, 4'h0, 4'h4);
    send(1, 1'b1, 8'h01);
    measure("t3_data01", 67, 4'h0, 4'h1);

    // Init not done: nothing accepted
    iInitDone = 1'b0;
    v0 = 1'b1; rs0 = 1'b1; b0 = 8'h55;
    n = 0;
    repeat (20) begin
      @(negedge Clock);
      n += int'(oReq0_Ready) + int'(oLCD_Enabled) + int'(oBusy);
    end
    check("t4_blocked", n, 0);
    tick();
    iInitDone = 1'b1;
    @(negedge Clock);
    check("t4_ready_now", int'(oReq0_Ready), 1);
    tick();
    v0 = 1'b0;
    measure("t4_byte", 67, 4'h5, 4'h5);

    // Reset during the low-nibble enable pulse
    send(0, 1'b1, 8'h6A);
    repeat (28) tick();
    @(negedge Clock);
    check("t5_in_pulse", int'(oLCD_Enabled), 1);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clock);
    check("t5_e", int'(oLCD_Enabled), 0);
    check("t5_data", int'(oLCD_Data), 0);
    check("t5_busy", int'(oBusy), 0);
    n = 0;
    repeat (60) begin
      @(negedge Clock);
      n += int'(oByteDone);
    end
    check("t5_no_done", n, 0);
    tick();
    send(1, 1'b1, 8'hC7);
    measure("t5_next", 67, 4'hC, 4'h7);

    // Random traffic against the model
    base = accepts;
    for (int i = 0; i < 8000 && accepts < base + 30; i++) begin
      tick();
      if (mAcc0) v0 = 1'b0;
      if (mAcc1) v1 = 1'b0;
      if (!v0 && $urandom_range(0, 3) == 0) begin
        rb = rndByte();
        v0 = 1'b1; rs0 = rb[8]; b0 = rb[7:0];
      end
      if (!v1 && $urandom_range(0, 3) == 0) begin
        rb = rndByte();
        v1 = 1'b1; rs1 = rb[8]; b1 = rb[7:0];
      end
      if ($urandom_range(0, 29) == 0) iInitDone = !iInitDone;
    end
    check("rand_accepts", int'(accepts >= base + 30), 1);
    v0 = 1'b0;
    v1 = 1'b0;
    iInitDone = 1'b1;
    for (int i = 0; i < 300 && mBusy; i++) tick();
    check("rand_drain", int'(mBusy), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
